// File: rtl/stream_demux_14_if.sv
// Handshake bundle for the 1:4 stream distributor.
//   master : producer + consumers side (drives in_valid/in_sel/in_data, out_ready)
//   slave  : the demux itself (drives in_ready, outN_data, out_valid, busy)
interface stream_demux_14_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, busy
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, busy
    );
endinterface

// File: rtl/stream_demux_14.sv
// One-to-four stream distributor. Each accepted input word is steered by
// in_sel into a one-entry holding register of that channel and held there
// until its consumer takes it. A stalled channel only blocks the producer
// while it is the selected destination.
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of stream_demux_14_if (input handshake, four output
//          channels, out_valid/out_ready vectors, busy)
module stream_demux_14 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_demux_14_if.slave      bus
);
    localparam int unsigned NCH = 4;

    logic [NCH-1:0]   v;
    logic [WIDTH-1:0] d [NCH];
    logic             xfer;

    // Ready when the destination slot is empty or is being emptied this cycle.
    assign bus.in_ready = ~v[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign xfer         = bus.in_valid & bus.in_ready;

    // Per-channel slot update; a load overrides a drain so back-to-back
    // words keep the slot valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                if (xfer && bus.in_sel == 2'(k)) begin
                    d[k] <= bus.in_data;
                    v[k] <= 1'b1;
                end else if (v[k] && bus.out_ready[k]) begin
                    v[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = v;
    assign bus.out0_data = d[0];
    assign bus.out1_data = d[1];
    assign bus.out2_data = d[2];
    assign bus.out3_data = d[3];
    assign bus.busy      = |v;

    // Producer must hold its offer stable until it is taken.
    a_producer_hold: assert property (
        @(posedge clk) disable iff (rst)
        (!rst && bus.in_valid && !bus.in_ready) |=>
            (bus.in_valid && bus.in_sel == $past(bus.in_sel) && bus.in_data == $past(bus.in_data))
    ) else $error("producer changed a pending offer");

    // A held, unconsumed word must not change under the consumer.
    for (genvar g = 0; g < int'(NCH); g++) begin : g_stable
        a_hold_stable: assert property (
            @(posedge clk) disable iff (rst)
            (!rst && v[g] && !bus.out_ready[g] && !(xfer && bus.in_sel == 2'(g))) |=>
                (v[g] && d[g] == $past(d[g]))
        ) else $error("held word changed while stalled");
    end
endmodule

// File: doc/stream_demux_14.md
Name: stream_demux_14

Overview:
- One-to-four stream distributor with valid/ready handshakes on every channel.
- Each accepted input word is steered by a 2-bit select to one of four output channels.
- Each output channel holds the word in a one-entry register until its consumer takes it.
- Sits opposite the 4:1 result muxes. It fans one producer, e.g. a memory/response path, out to four consumers.
- Allows full throughput per channel, and lets one channel stall without blocking traffic to the others whenever the stalled channel is not selected.

Parameters:
- WIDTH, 32, data width of input and each output channel.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word on in_data/in_sel
- in_sel  input  2  destination channel, 0..3
- in_data  input  WIDTH  word to deliver
- in_ready  output  1  block accepts the word this cycle
- out0_data  output  WIDTH  channel 0 held word
- out1_data  output  WIDTH  channel 1 held word
- out2_data  output  WIDTH  channel 2 held word
- out3_data  output  WIDTH  channel 3 held word
- out_valid  output  4  bit k: channel k holds a valid word
- out_ready  input  4  bit k: consumer k takes the word this cycle
- busy  output  1  OR of out_valid

Behaviour:
- State per channel k: valid flag v[k] and data register d[k]. out_valid = v, outk_data = d[k], busy = |v.
- Reset, when rst is high at a clock edge:
  - v = 0 and all d[k] = 0.
  - Pending words are dropped, no handshake completes, and a same-cycle input is not accepted.
  - in_ready is still driven combinationally during reset, but acceptance is ignored.
- Input handshake:
  - in_ready = ~v[in_sel] | out_ready[in_sel]. It is combinational from in_sel, v and out_ready, and does not depend on in_valid.
  - A transfer occurs when in_valid & in_ready.
- Output handshake:
  - Channel k drains when v[k] & out_ready[k].
  - out_ready[k] while v[k] = 0 has no effect.
- Per-channel update at the clock edge, for channel s = in_sel:
  - transfer and drain: d[s] <= in_data, v[s] stays 1 (back-to-back, full throughput)
  - transfer only: d[s] <= in_data, v[s] <= 1
  - drain only: v[k] <= 0, d[k] retained
  - neither: hold
- Latency: a word accepted at edge N is visible at outk on cycle N+1. It is not combinationally forwarded.
- Channels not equal to in_sel drain independently in the same cycle as an input transfer.
- Ordering:
  - Words to the same channel are delivered in acceptance order.
  - No ordering is guaranteed across channels.
- Stability: while v[k] = 1 and out_ready[k] = 0, d[k] is held constant.
- Producer rules: the producer may change in_sel/in_data while in_valid = 0. Once in_valid is asserted it holds in_sel/in_data until the transfer. Checker assertion required.
- All four in_sel values are legal; there is no error case.
- No word loss or duplication: every accepted word drains exactly once unless rst intervenes.

Test Plan:
1. rst held 2 cycles -> out_valid = 4'b0000, all outk_data = 0, busy = 0; in_ready = 1 for every in_sel.
2. out_ready = 4'hF; send 0xA0000000..0xA0000003 with in_sel 0,1,2,3 on consecutive cycles -> each word appears on its channel exactly one cycle after acceptance; in_ready stays 1; no bubbles.
3. out_ready[2] = 0; send 0x11111111 (sel 2), then 0x22222222 (sel 2):
   - First word is accepted and v[2] = 1.
   - Second word stalls with in_ready = 0 and out2_data stable at 0x11111111.
   - Raise out_ready[2] -> in the same cycle the first word drains and the second is accepted; next cycle out2_data = 0x22222222.
4. Channel 2 stalled full with out_ready[2] = 0; send 0x33333333 to sel 0 -> accepted immediately; out0_data = 0x33333333 next cycle; channel 2 unchanged.
5. Random in_valid/in_sel/out_ready for 10k cycles, scoreboard per channel -> in-order, lossless, no duplicates, and the stability assertion holds.
6. Fill channels 1 and 3 (0xDEADBEEF, 0xCAFEF00D) with out_ready = 0, then assert rst for one cycle during an in_valid transfer -> next cycle out_valid = 0 and the transfer is not counted by the scoreboard.
